// File: rtl/mha_head_sched.sv
// ============================================================================
//  Module   : mha_head_sched
//  Purpose  : Multi-head attention scheduler. Slices the full Q/K/V matrices
//             into one head at a time, launches the single-head attention
//             core for each unmasked head, and packs the per-head results
//             into a SEQ x D_MODEL output buffer. Provides per-head masking,
//             a per-head completion watchdog and a core clear between heads.
//  Ports    : I_CLK, I_ASYN_RSTN (async, active-low), I_SYNC_RSTN (sync,
//             active-low) ; I_MHA_START / I_HEAD_MASK : run request ;
//             I_MAT_Q/K/V : full matrices ; O_HEAD_Q/K/V : current head slice ;
//             O_ATTN_START / O_CORE_CLEARN / I_ATT_VLD / I_ATT_DATA : core
//             handshake ; O_HEAD_IDX, O_BUSY, O_DONE, O_ERR : status ;
//             O_MHA_DATA : packed result.
//  Layout   : matrices are flattened; element [r][c] of a matrix with C
//             columns sits at bits [(r*C+c)*D_W +: D_W].
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mha_head_sched #(
    parameter int D_W     = 8,
    parameter int SEQ     = 16,
    parameter int D_K     = 16,
    parameter int H_NUM   = 4,
    parameter int TIMEOUT = 4096,
    localparam int D_MODEL = H_NUM * D_K,
    localparam int IDX_W   = (H_NUM > 1) ? $clog2(H_NUM) : 1
) (
    input  logic                         I_CLK,
    input  logic                         I_ASYN_RSTN,
    input  logic                         I_SYNC_RSTN,
    input  logic                         I_MHA_START,
    input  logic [H_NUM-1:0]             I_HEAD_MASK,
    input  logic [SEQ*D_MODEL*D_W-1:0]   I_MAT_Q,
    input  logic [SEQ*D_MODEL*D_W-1:0]   I_MAT_K,
    input  logic [SEQ*D_MODEL*D_W-1:0]   I_MAT_V,
    output logic                         O_ATTN_START,
    output logic                         O_CORE_CLEARN,
    output logic [SEQ*D_K*D_W-1:0]       O_HEAD_Q,
    output logic [SEQ*D_K*D_W-1:0]       O_HEAD_K,
    output logic [SEQ*D_K*D_W-1:0]       O_HEAD_V,
    input  logic                         I_ATT_VLD,
    input  logic [SEQ*D_K*D_W-1:0]       I_ATT_DATA,
    output logic [IDX_W-1:0]             O_HEAD_IDX,
    output logic                         O_BUSY,
    output logic                         O_DONE,
    output logic                         O_ERR,
    output logic [SEQ*D_MODEL*D_W-1:0]   O_MHA_DATA
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(H_NUM - 1);
    localparam int ROW_BITS = D_K * D_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEEK   = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_CLEAR  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [H_NUM-1:0]            r_mask;
    logic [IDX_W-1:0]            r_idx;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_err;
    logic [SEQ*D_MODEL*D_W-1:0]  r_data;

    logic                        w_accept;
    logic                        w_idx_inc;
    logic                        w_store;
    logic                        w_timeout;
    logic                        w_last;
    logic [CNT_W-1:0]            w_cnt_inc;

    assign w_last    = (r_idx == C_IDX_LAST);
    // The watchdog fires on the edge where the counter would reach
    // TIMEOUT-1, so a head gets exactly TIMEOUT-1 WAIT cycles.
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_idx_inc = 1'b0;
        w_store   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (I_MHA_START) begin
                    w_accept = 1'b1;
                    w_next   = S_SEEK;
                end
            end
            S_SEEK: begin
                if (!r_mask[r_idx]) begin
                    w_next = S_LAUNCH;
                end else if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_idx_inc = 1'b1;
                end
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                // Valid takes priority over a coincident timeout.
                if (I_ATT_VLD) begin
                    w_store = 1'b1;
                    w_next  = S_CLEAR;
                end else if (w_cnt_inc == C_TMO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_CLEAR: begin
                if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_idx_inc = 1'b1;
                    w_next    = S_SEEK;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (!I_SYNC_RSTN) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mask <= I_HEAD_MASK;
                r_idx  <= '0;
                r_err  <= 1'b0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (r_state == S_LAUNCH) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Result buffer: cleared on an accepted start, one head's column block
    // written when the core reports valid.
    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            r_data <= '0;
        end else if (!I_SYNC_RSTN) begin
            r_data <= '0;
        end else if (w_accept) begin
            r_data <= '0;
        end else if (w_store) begin
            for (int r = 0; r < SEQ; r++) begin
                r_data[(r*D_MODEL + int'(r_idx)*D_K)*D_W +: ROW_BITS]
                    <= I_ATT_DATA[r*ROW_BITS +: ROW_BITS];
            end
        end
    end

    generate
        for (genvar r = 0; r < SEQ; r++) begin : g_slice
            assign O_HEAD_Q[r*ROW_BITS +: ROW_BITS] =
                I_MAT_Q[(r*D_MODEL + int'(r_idx)*D_K)*D_W +: ROW_BITS];
            assign O_HEAD_K[r*ROW_BITS +: ROW_BITS] =
                I_MAT_K[(r*D_MODEL + int'(r_idx)*D_K)*D_W +: ROW_BITS];
            assign O_HEAD_V[r*ROW_BITS +: ROW_BITS] =
                I_MAT_V[(r*D_MODEL + int'(r_idx)*D_K)*D_W +: ROW_BITS];
        end
    endgenerate

    assign O_ATTN_START  = (r_state == S_LAUNCH);
    assign O_CORE_CLEARN = (r_state != S_CLEAR);
    assign O_BUSY        = (r_state != S_IDLE);
    assign O_DONE        = (r_state == S_DONE);
    assign O_ERR         = r_err;
    assign O_HEAD_IDX    = r_idx;
    assign O_MHA_DATA    = r_data;

endmodule

`default_nettype wire
